pipe_reg_skid: RTL and testbench
================================

# pipe_reg_skid

Parametrised, elastic pipeline-stage register used between any two core stages. It replaces fixed stall-vector pipeline registers with a valid/ready handshake and a one-entry skid buffer, so back-pressure is absorbed without a combinational ready path. Flush inserts a bubble, and invalid slots present a configurable NOP pattern downstream. Each inter-stage boundary instantiates one copy, with the stage's control and data fields concatenated into `in_data`.

## Interface

Parameters:
- `DATA_W`, 32: width of the payload carried through the stage; must be at least 1.
- `NOP_VALUE`, `{DATA_W{1'b0}}`: payload presented on `out_data` whenever `out_valid` = 0. Set it so that all write-enables decode as 0.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `flush`, input, 1: discard all held entries; takes effect at the next edge.
- `in_valid`, input, 1: upstream holds a valid payload.
- `in_ready`, output, 1: stage can accept a payload this cycle; driven from a register.
- `in_data`, input, DATA_W: upstream payload.
- `out_valid`, output, 1: `out_data` holds a valid payload.
- `out_ready`, input, 1: downstream consumes the payload this cycle.
- `out_data`, output, DATA_W: payload presented to downstream, driven from a register.
- `occupancy`, output, 2: number of held entries, 0 to 2.

## Operation

- Storage:
  - main register `m_data`/`m_valid` drives `out_data`/`out_valid`;
  - skid register `s_data`/`s_valid` holds overflow.
- Handshake events:
  - accept = `in_valid & in_ready`;
  - drain = `out_valid & out_ready`.
- `in_ready` = `!s_valid` (registered).
- `occupancy` = `m_valid + s_valid`.
- States and transitions; any combination not listed holds all registers:
  - **EMPTY** (`m_valid`=0, `s_valid`=0):
    - accept → ONE, with `m_data` <= `in_data`.
  - **ONE** (`m_valid`=1, `s_valid`=0):
    - accept & drain → ONE, with `m_data` <= `in_data`;
    - accept & !drain → FULL, with `s_data` <= `in_data`;
    - !accept & drain → EMPTY, with `m_data` <= `NOP_VALUE`.
  - **FULL** (`m_valid`=1, `s_valid`=1; `in_ready`=0):
    - drain → ONE, with `m_data` <= `s_data` and `s_data` <= `NOP_VALUE`.
- `out_data` equals `NOP_VALUE` whenever `out_valid` = 0. Any transition that clears a valid bit also loads `NOP_VALUE` into the matching data register.
- Entries leave in exactly the order they were accepted; nothing is dropped or duplicated unless `flush` is asserted.
- Priority at each edge: `rst` > `flush` > handshake.
  - `flush`: go to EMPTY and load both data registers with `NOP_VALUE`. Any accept or drain in the same cycle is ignored: the upstream payload is discarded, and the downstream consumer must ignore that cycle's output.
- State FULL→EMPTY is reachable only through `flush`.
- `in_data` is not sampled unless accept is true.

## Timing

- Reset values:
  - `out_valid` = 0;
  - `out_data` = `NOP_VALUE`;
  - `in_ready` = 1;
  - `occupancy` = 0;
  - skid register empty and loaded with `NOP_VALUE`.
- A reset asserted mid-operation discards all entries at that edge, exactly as at power-up.
- Latency: a payload accepted at edge N is visible on `out_data` at edge N with `out_valid` = 1 (one register stage), when the stage was EMPTY or draining.
- Throughput: one payload per cycle while `out_ready` = 1.
- Back-pressure:
  - after `out_ready` drops, `in_ready` falls one cycle later;
  - the single extra payload accepted in that cycle lands in the skid register.
- Recovery: once `out_ready` rises in FULL, `in_ready` rises one edge later.
- No combinational path from `out_ready` to `in_ready`, or from `in_*` to `out_*`.
- `flush` held for several cycles keeps the stage EMPTY and `in_ready` = 1. It accepts nothing while held.

## Test plan

1. Reset and streaming:
   - Stimulus: `rst`=1 for 2 cycles, then `in_valid`=1 with data 0x11, 0x22, 0x33 on consecutive cycles and `out_ready`=1.
   - Required response: during reset, `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1. Then `out_data` = 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its accept, with `occupancy` = 1 throughout.
2. Skid fill:
   - Stimulus: stream 0xA0, 0xA1, 0xA2 and drop `out_ready` in the cycle 0xA1 is offered.
   - Required response: 0xA0 stays on the output; 0xA1 goes into the skid register; `in_ready`=0 and `occupancy`=2 at the next edge; 0xA2 is held upstream.
3. Skid drain:
   - Stimulus: from the end state of scenario 2, raise `out_ready`.
   - Required response: output order is 0xA0, 0xA1, 0xA2 with no gap after `in_ready` recovers; no loss or duplication.
4. Flush in FULL:
   - Stimulus: `flush`=1 for 1 cycle while in FULL with `in_valid`=1.
   - Required response: next cycle `out_valid`=0, `out_data`=`NOP_VALUE`, `occupancy`=0, `in_ready`=1; the payload offered in the flush cycle never appears at the output.
5. Simultaneous accept and drain in ONE:
   - Stimulus: 1000 cycles of random `in_valid`/`out_ready`.
   - Required response: a scoreboard confirms in-order, lossless delivery; `occupancy` never exceeds 2; `in_ready` never rises while `s_valid`=1.
6. Reset mid-FULL:
   - Stimulus: `rst`=1 for 1 cycle while FULL, with `flush`=1 and `in_valid`=1 in the same cycle.
   - Required response: reset values on all outputs at the next edge; nothing is accepted.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - elastic pipeline-stage register with one-entry skid buffer
// State bits double as the valid flags: bit0 = main valid, bit1 = skid valid.
module pipe_reg_skid #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              accept;
  logic              drain;

  // Ready and valid come straight from state flops, so no combinational path crosses the stage.
  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, state_q[0]} + {1'b0, state_q[1]};

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = NOP_VALUE;
      s_data_d = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            m_data_d = in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            m_data_d = in_data;
          end else if (accept) begin
            state_d  = FULL;
            s_data_d = in_data;
          end else if (drain) begin
            state_d  = EMPTY;
            m_data_d = NOP_VALUE;
          end
        end
        FULL: begin
          if (drain) begin
            state_d  = ONE;
            m_data_d = s_data_q;
            s_data_d = NOP_VALUE;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_data_d = NOP_VALUE;
          s_data_d = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      m_data_q <= NOP_VALUE;
      s_data_q <= NOP_VALUE;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb/tb_pipe_reg_skid.sv - directed and scoreboarded bench for pipe_reg_skid
module tb_pipe_reg_skid;

  localparam int          DATA_W = 8;
  localparam logic [7:0]  NOP    = 8'hEE;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_reg_skid #(.DATA_W(DATA_W), .NOP_VALUE(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== NOP) begin n_fail++; $display("FAIL reset_out_data got %h want %h", out_data, NOP); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1);
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin n_fail++; $display("FAIL stream_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, vals[i]); end
      n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_occ_%0d got occ=%0d rdy=%b want occ=1 rdy=1", i, occupancy, in_ready); end
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_empty got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid, out_data, occupancy, NOP); end
  endtask

  task automatic test_skid_fill();
    drive(1'b1, 8'hA0, 1'b1);
    tick();
    n_checks++; if (out_data !== 8'hA0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_a0 got v=%b d=%h want v=1 d=a0", out_valid, out_data); end
    drive(1'b1, 8'hA1, 1'b0);
    tick();
    n_checks++; if (out_data !== 8'hA0 || occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got d=%h occ=%0d rdy=%b want d=a0 occ=2 rdy=0", out_data, occupancy, in_ready); end
    drive(1'b1, 8'hA2, 1'b0);
    tick();
    n_checks++; if (out_data !== 8'hA0 || occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_hold got d=%h occ=%0d rdy=%b want d=a0 occ=2 rdy=0", out_data, occupancy, in_ready); end
  endtask

  task automatic test_skid_drain();
    drive(1'b1, 8'hA2, 1'b1);
    tick();
    n_checks++; if (out_data !== 8'hA1 || out_valid !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_a1 got d=%h v=%b occ=%0d rdy=%b want d=a1 v=1 occ=1 rdy=1", out_data, out_valid, occupancy, in_ready); end
    tick();
    n_checks++; if (out_data !== 8'hA2 || out_valid !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL drain_a2 got d=%h v=%b occ=%0d want d=a2 v=1 occ=1", out_data, out_valid, occupancy); end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin n_fail++; $display("FAIL drain_empty got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid, out_data, occupancy, NOP); end
  endtask

  task automatic test_flush();
    drive(1'b1, 8'hB0, 1'b1);
    tick();
    drive(1'b1, 8'hB1, 1'b0);
    tick();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_full got occ=%0d want 2", occupancy); end
    flush = 1'b1; drive(1'b1, 8'hB2, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full got v=%b d=%h occ=%0d rdy=%b want v=0 d=%h occ=0 rdy=1", out_valid, out_data, occupancy, in_ready, NOP); end
    drive(1'b1, 8'hB3, 1'b1);
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_held got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", out_valid, occupancy, in_ready); end
    flush = 1'b0; drive(1'b0, 8'h00, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin n_fail++; $display("FAIL flush_no_leak got v=%b d=%h want v=0 d=%h", out_valid, out_data, NOP); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       exp_rdy = 1'b1;
    logic       acc, drn;
    logic [7:0] exp_d;
    for (int c = 0; c < 1000; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      acc = in_valid && exp_rdy;
      drn = (q.size() > 0) && out_ready;
      tick();
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(in_data);
      exp_rdy = (q.size() < 2);
      exp_d   = (q.size() > 0) ? q[0] : NOP;
      n_checks++; if (out_valid !== (q.size() > 0) || out_data !== exp_d) begin n_fail++; $display("FAIL rand_out cyc=%0d got v=%b d=%h want v=%b d=%h", c, out_valid, out_data, q.size() > 0, exp_d); end
      n_checks++; if (occupancy !== 2'(q.size()) || in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_state cyc=%0d got occ=%0d rdy=%b want occ=%0d rdy=%b", c, occupancy, in_ready, q.size(), exp_rdy); end
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rand_drain got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid_full();
    drive(1'b1, 8'hC0, 1'b1);
    tick();
    drive(1'b1, 8'hC1, 1'b0);
    tick();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL rstfull_pre got occ=%0d want 2", occupancy); end
    rst = 1'b1; flush = 1'b1; drive(1'b1, 8'hC2, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull got v=%b d=%h occ=%0d rdy=%b want v=0 d=%h occ=0 rdy=1", out_valid, out_data, occupancy, in_ready, NOP); end
    rst = 1'b0; flush = 1'b0; drive(1'b0, 8'h00, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin n_fail++; $display("FAIL rstfull_nothing got v=%b d=%h want v=0 d=%h", out_valid, out_data, NOP); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_skid_drain();
    test_flush();
    test_random();
    test_reset_mid_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
